// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo; the status signals exist only when FIFO_STATUS_EN is defined.
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
);
   localparam int ADDR_W = $clog2(FIFO_DEPTH);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic                  wr_ready;
   logic                  rd_val;
   logic [DATA_WIDTH-1:0] rd_data;

`ifdef FIFO_STATUS_EN
   logic [ADDR_W:0]       level;
   logic                  overflow;
   logic                  underflow;

   modport master (output wr_en, wr_data, rd_en,
                   input  wr_ready, rd_val, rd_data, level, overflow, underflow);
   modport slave  (input  wr_en, wr_data, rd_en,
                   output wr_ready, rd_val, rd_data, level, overflow, underflow);
`else
   modport master (output wr_en, wr_data, rd_en,
                   input  wr_ready, rd_val, rd_data);
   modport slave  (input  wr_en, wr_data, rd_en,
                   output wr_ready, rd_val, rd_data);
`endif
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (one cycle from accepted read to rd_val); wr_ready drops when full,
// reads while empty are ignored. Defining FIFO_STATUS_EN adds level/overflow/underflow outputs.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   sync_fifo_if.slave  bus
);
   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W:0]       wr_ptr;
   logic [ADDR_W:0]       rd_ptr;
   logic                  rd_val_q;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  full;
   logic                  empty;
   logic                  wr_acc;
   logic                  rd_acc;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   assign bus.wr_ready = reset && !full;
   assign wr_acc       = bus.wr_en && bus.wr_ready;
   assign rd_acc       = bus.rd_en && !empty;

   assign bus.rd_val   = rd_val_q;
   assign bus.rd_data  = rd_data_q;

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rd_val_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         rd_val_q <= rd_acc;
         if (rd_acc) begin
            rd_data_q <= mem[rd_ptr[ADDR_W-1:0]];
            rd_ptr    <= rd_ptr + PTR_ONE;
         end
      end
   end

`ifdef FIFO_STATUS_EN
   logic overflow_q;
   logic underflow_q;

   assign bus.level     = wr_ptr - rd_ptr;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.wr_en && full) begin
            overflow_q <= 1'b1;
         end
         if (bus.rd_en && empty) begin
            underflow_q <= 1'b1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_sync_fifo;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   sync_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

   sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: contents as a queue plus the expected registered read outputs.
   logic [DW-1:0] q[$];
   logic          exp_val;
   logic [DW-1:0] exp_data;
   logic          exp_ov;
   logic          exp_un;

   task automatic model_reset();
      q.delete();
      exp_val  = 1'b0;
      exp_data = '0;
      exp_ov   = 1'b0;
      exp_un   = 1'b0;
   endtask

   // Drive one clock of requests (from a negedge) and advance the model at the posedge.
   task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re);
      bit is_full;
      bit is_empty;
      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.rd_en   = re;
      @(posedge clk);
      is_full  = (q.size() == DEPTH);
      is_empty = (q.size() == 0);
      exp_ov   = exp_ov | (we && is_full);
      exp_un   = exp_un | (re && is_empty);
      exp_val  = re && !is_empty;
      if (exp_val) exp_data = q.pop_front();
      if (we && !is_full) q.push_back(wd);
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({bus.wr_ready, bus.rd_val, bus.rd_data} !== {1'b0, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL reset_held {wr_ready,rd_val,rd_data} got=%h want=%h",
                  {bus.wr_ready, bus.rd_val, bus.rd_data}, {1'b0, 1'b0, 8'h00});
      end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      total++;
      if ({bus.wr_ready, bus.rd_val, bus.rd_data} !== {1'b1, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL reset_idle {wr_ready,rd_val,rd_data} got=%h want=%h",
                  {bus.wr_ready, bus.rd_val, bus.rd_data}, {1'b1, 1'b0, 8'h00});
      end
`ifdef FIFO_STATUS_EN
      total++;
      if ({bus.level, bus.overflow, bus.underflow} !== 5'b0) begin
         bad++;
         $display("FAIL reset_status got=%b want=%b", {bus.level, bus.overflow, bus.underflow}, 5'b0);
      end
`endif
      @(negedge clk);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, DW'(i), 1'b0);
         total++;
         if ({bus.wr_ready, bus.rd_val} !== {(i < 3) ? 1'b1 : 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL fill_%0d {wr_ready,rd_val} got=%b want=%b", i,
                     {bus.wr_ready, bus.rd_val}, {(i < 3) ? 1'b1 : 1'b0, 1'b0});
         end
      end
      cycle(1'b1, 8'h09, 1'b0);
      total++;
      if (bus.wr_ready !== 1'b0 || q.size() != DEPTH) begin
         bad++;
         $display("FAIL fill_overrun wr_ready got=%b want=0", bus.wr_ready);
      end
`ifdef FIFO_STATUS_EN
      total++;
      if ({bus.level, bus.overflow} !== {3'd4, 1'b1}) begin
         bad++;
         $display("FAIL fill_status {level,overflow} got=%b want=%b", {bus.level, bus.overflow}, {3'd4, 1'b1});
      end
`endif
   endtask

   task automatic test_drain();
      for (int i = 0; i < 5; i++) begin
         logic [9:0] want;
         cycle(1'b0, 8'h00, 1'b1);
         want = (i < 4) ? {1'b1, DW'(i), 1'b1} : {1'b0, 8'h03, 1'b1};
         total++;
         if ({bus.rd_val, bus.rd_data, bus.wr_ready} !== want) begin
            bad++;
            $display("FAIL drain_%0d {rd_val,rd_data,wr_ready} got=%h want=%h", i,
                     {bus.rd_val, bus.rd_data, bus.wr_ready}, want);
         end
      end
`ifdef FIFO_STATUS_EN
      total++;
      if ({bus.level, bus.underflow} !== {3'd0, 1'b1}) begin
         bad++;
         $display("FAIL drain_status {level,underflow} got=%b want=%b", {bus.level, bus.underflow}, {3'd0, 1'b1});
      end
`endif
   endtask

   task automatic test_concurrent();
      for (int i = 0; i < DEPTH && q.size() > 0; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b1, 8'hA1, 1'b0);
      cycle(1'b1, 8'hB2, 1'b0);
      cycle(1'b1, 8'hC3, 1'b1);
      total++;
      if ({bus.rd_val, bus.rd_data} !== {1'b1, 8'hA1}) begin
         bad++;
         $display("FAIL concurrent_a got=%h want=%h", {bus.rd_val, bus.rd_data}, {1'b1, 8'hA1});
      end
`ifdef FIFO_STATUS_EN
      total++;
      if (bus.level !== 3'd2) begin
         bad++;
         $display("FAIL concurrent_level got=%0d want=2", bus.level);
      end
`endif
      cycle(1'b0, 8'h00, 1'b1);
      total++;
      if ({bus.rd_val, bus.rd_data} !== {1'b1, 8'hB2}) begin
         bad++;
         $display("FAIL concurrent_b got=%h want=%h", {bus.rd_val, bus.rd_data}, {1'b1, 8'hB2});
      end
      cycle(1'b0, 8'h00, 1'b1);
      total++;
      if ({bus.rd_val, bus.rd_data} !== {1'b1, 8'hC3}) begin
         bad++;
         $display("FAIL concurrent_c got=%h want=%h", {bus.rd_val, bus.rd_data}, {1'b1, 8'hC3});
      end
   endtask

   task automatic test_wrap();
      int nw = 0;
      int nr = 0;
      for (int c = 0; c < 200 && nr < 10; c++) begin
         logic we;
         logic re;
         we = (nw < 10) && (q.size() < DEPTH) && 1'($urandom);
         re = 1'($urandom);
         cycle(we, DW'(8'h10 + nw), re);
         if (we) nw++;
         if (exp_val) begin
            total++;
            if ({bus.rd_val, bus.rd_data} !== {1'b1, DW'(8'h10 + nr)}) begin
               bad++;
               $display("FAIL wrap_%0d {rd_val,rd_data} got=%h want=%h", nr,
                        {bus.rd_val, bus.rd_data}, {1'b1, DW'(8'h10 + nr)});
            end
            nr++;
         end
      end
      total++;
      if (nr != 10) begin
         bad++;
         $display("FAIL wrap_timeout words_read got=%0d want=10", nr);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         cycle(1'($urandom), DW'($urandom), 1'($urandom));
         total++;
         if ({bus.rd_val, bus.rd_data, bus.wr_ready} !==
             {exp_val, exp_data, (q.size() < DEPTH) ? 1'b1 : 1'b0}) begin
            bad++;
            $display("FAIL random_%0d {rd_val,rd_data,wr_ready} got=%h want=%h", c,
                     {bus.rd_val, bus.rd_data, bus.wr_ready},
                     {exp_val, exp_data, (q.size() < DEPTH) ? 1'b1 : 1'b0});
         end
`ifdef FIFO_STATUS_EN
         total++;
         if ({bus.level, bus.overflow, bus.underflow} !== {3'(q.size()), exp_ov, exp_un}) begin
            bad++;
            $display("FAIL random_status_%0d got=%b want=%b", c,
                     {bus.level, bus.overflow, bus.underflow}, {3'(q.size()), exp_ov, exp_un});
         end
`endif
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < DEPTH && q.size() < 3; i++) cycle(1'b1, DW'($urandom), 1'b0);
      for (int i = 0; i < DEPTH && q.size() > 3; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b1, 8'h5A, 1'b1);
      total++;
      if (bus.rd_val !== 1'b1 || q.size() != 3) begin
         bad++;
         $display("FAIL areset_pre rd_val got=%b want=1", bus.rd_val);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({bus.rd_val, bus.rd_data, bus.wr_ready} !== {1'b0, 8'h00, 1'b0}) begin
         bad++;
         $display("FAIL areset_held {rd_val,rd_data,wr_ready} got=%h want=%h",
                  {bus.rd_val, bus.rd_data, bus.wr_ready}, {1'b0, 8'h00, 1'b0});
      end
      #1 reset = 1'b1;
      model_reset();
      @(negedge clk);
      total++;
      if (bus.wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL areset_ready got=%b want=1", bus.wr_ready);
      end
`ifdef FIFO_STATUS_EN
      total++;
      if ({bus.level, bus.overflow, bus.underflow} !== 5'b0) begin
         bad++;
         $display("FAIL areset_status got=%b want=%b", {bus.level, bus.overflow, bus.underflow}, 5'b0);
      end
`endif
      cycle(1'b0, 8'h00, 1'b1);
      total++;
      if ({bus.rd_val, bus.rd_data} !== {1'b0, 8'h00}) begin
         bad++;
         $display("FAIL areset_empty_read got=%h want=%h", {bus.rd_val, bus.rd_data}, {1'b0, 8'h00});
      end
      cycle(1'b1, 8'hE7, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      total++;
      if ({bus.rd_val, bus.rd_data} !== {1'b1, 8'hE7}) begin
         bad++;
         $display("FAIL areset_resume got=%h want=%h", {bus.rd_val, bus.rd_data}, {1'b1, 8'hE7});
      end
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;
      model_reset();
      test_reset();
      test_fill();
      test_drain();
      test_concurrent();
      test_wrap();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, parameterised first-in first-out buffer with a write-ready / read-valid handshake.
- Used as a general-purpose elastic buffer between a producer and a consumer in the same clock domain.
- Storage is a register array. Read data is registered: one cycle of latency from an accepted read to valid data.

Parameters:
- DATA_WIDTH, default 8: width of each stored word in bits.
- FIFO_DEPTH, default 4: number of entries. Must be a power of two, at least 2.
- Derived (local, not overridable) ADDR_W = clog2(FIFO_DEPTH). Pointers are ADDR_W+1 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  data to push.
- rd_en  input  1  read request.
- wr_ready  output  1  FIFO can accept a write this cycle.
- rd_val  output  1  rd_data holds a freshly popped word this cycle.
- rd_data  output  DATA_WIDTH  popped word.

Behaviour:
- Reset (reset=0, asynchronous assertion):
  - wr_ptr=0, rd_ptr=0, rd_val=0, rd_data=0.
  - wr_ready=0 while reset is held; the storage array is not cleared.
- After reset deasserts:
  - FIFO is empty; wr_ready=1 combinationally.
- Full / empty:
  - full when pointer MSBs differ and the lower ADDR_W bits are equal.
  - empty when the pointers are equal.
- wr_ready = !full (and 0 in reset). It is combinational from registered pointers and has no dependence on rd_en.
- Write:
  - Accepted at a rising edge when wr_en=1 and wr_ready=1.
  - mem[wr_ptr[ADDR_W-1:0]] <= wr_data; wr_ptr increments.
  - wr_en while full: ignored, no state change, no data corruption.
- Read:
  - Accepted at a rising edge when rd_en=1 and the FIFO is not empty.
  - rd_data <= mem[rd_ptr[ADDR_W-1:0]]; rd_ptr increments; rd_val <= 1.
  - Otherwise rd_val <= 0 and rd_data holds its last value.
  - rd_en while empty: ignored, rd_val=0.
- Latency:
  - Data written at edge N can first be read by a read accepted at edge N+1; it appears on rd_data after that edge.
  - No write-to-read bypass.
- Simultaneous wr_en and rd_en:
  - Both are accepted if their individual conditions hold; occupancy is unchanged.
  - When full, the write is refused even though a read frees a slot in the same cycle.
  - When empty, only the write is accepted.
- Wrap-around: pointers wrap naturally modulo 2*FIFO_DEPTH; ordering is preserved across wraps.
- Reset mid-operation: all contents are logically discarded and the FIFO returns to empty immediately.

Optional Feature:
- Macro FIFO_STATUS_EN.
- When defined, three extra outputs are added:
  - level (ADDR_W+1 bits): current occupancy = wr_ptr - rd_ptr, range 0..FIFO_DEPTH.
  - overflow (1): sticky, set on any cycle with wr_en=1 while full.
  - underflow (1): sticky, set on any cycle with rd_en=1 while empty.
- level, overflow and underflow are cleared only by reset.
- When not defined, these ports and their logic do not exist; core behaviour is identical.

Test Plan:
- Reset then idle: reset=0 for 1 cycle, then 1 -> wr_ready=1, rd_val=0, rd_data=0.
- Fill: write 0,1,2,3 on four consecutive cycles (DEPTH=4) -> wr_ready=1 after writes 1-3, wr_ready=0 after the 4th; a 5th write of 9 is ignored (overflow=1 if FIFO_STATUS_EN).
- Drain: rd_en=1 for 5 cycles after fill -> rd_val=1 with rd_data=0,1,2,3 on consecutive cycles. The 5th read gives rd_val=0 and rd_data stays 3 (underflow=1 if enabled); wr_ready returns to 1 after the first read.
- Concurrent: with 2 entries (A,B) present, wr_en and rd_en together with data C -> rd_data=A, level stays 2; subsequent reads return B then C.
- Wrap: write/read 10 words 0x10..0x19 interleaved, never exceeding depth -> output order 0x10..0x19 exactly.
- Async reset mid-stream: with 3 entries, pulse reset=0 between edges -> rd_val=0 immediately, then the FIFO reads as empty (rd_en gives rd_val=0) and wr_ready=1.
